// File: rtl/stream_adder_fifo.sv
// -----------------------------------------------------------------------------
// stream_adder_fifo
//
// Purpose:
//   Accepts WIDTH-bit words on a val/rdy input stream and applies a per-beat
//   operation selected by i_op: add constant INC, add cfg_addend, accumulate
//   into an internal register, or pass through unchanged. Each result is
//   written into a DEPTH-entry output FIFO on the accepting clock edge, so the
//   input and output sides can both fire in the same cycle. A sticky flag
//   records whether any stored result carried out of WIDTH bits.
//
// Handshake:
//   A beat transfers on a rising clk edge where val and rdy are both 1. The
//   producer holds val and data stable until the transfer. i_stream_rdy
//   depends only on the FIFO occupancy. o_stream_val and o_stream_data depend
//   only on registered state. No input reaches an output combinationally.
//
// Ports:
//   clk            clock; all logic on posedge
//   reset          synchronous, active-low (0 = reset)
//   i_stream_val   input word valid
//   i_stream_rdy   block can accept a word (FIFO not full)
//   i_stream_data  input word
//   i_op           operation, sampled with each accepted beat
//                    00 INC, 01 ADD, 10 ACC, 11 PASS
//   cfg_addend     addend for OP_ADD, sampled at accept
//   cfg_clear      1-cycle pulse: clear accumulator and overflow flag
//   o_stream_val   FIFO head valid
//   o_stream_rdy   consumer accepts head
//   o_stream_data  FIFO head word (don't-care when empty)
//   o_count        FIFO occupancy, 0..DEPTH
//   o_overflow     sticky carry-out flag
//   o_acc          current accumulator value (observation only)
// -----------------------------------------------------------------------------
module stream_adder_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int INC   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_stream_val,
  output logic                       i_stream_rdy,
  input  logic [WIDTH-1:0]           i_stream_data,
  input  logic [1:0]                 i_op,
  input  logic [WIDTH-1:0]           cfg_addend,
  input  logic                       cfg_clear,
  output logic                       o_stream_val,
  input  logic                       o_stream_rdy,
  output logic [WIDTH-1:0]           o_stream_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_overflow,
  output logic [WIDTH-1:0]           o_acc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  localparam logic [1:0] OP_INC  = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_ACC  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  localparam logic [WIDTH-1:0] INC_W   = WIDTH'(INC);
  localparam logic [CW-1:0]    COUNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0]    COUNT_ONE  = CW'(1);
  localparam logic [AW-1:0]    PTR_ONE    = AW'(1);

  // Storage and state
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc;
  logic             overflow;

  logic             push;
  logic             pop;
  logic [WIDTH:0]   result;

  // Handshake decode
  assign i_stream_rdy  = (count != COUNT_FULL);
  assign o_stream_val  = (count != '0);
  assign push          = i_stream_val & i_stream_rdy;
  assign pop           = o_stream_val & o_stream_rdy;

  assign o_stream_data = mem[rd_ptr];
  assign o_count       = count;
  assign o_overflow    = overflow;
  assign o_acc         = acc;

  // Per-beat operation. The extra top bit holds the carry-out; PASS never
  // carries because its top bit is forced to zero.
  always_comb begin
    result = '0;
    unique case (i_op)
      OP_INC:  result = {1'b0, i_stream_data} + {1'b0, INC_W};
      OP_ADD:  result = {1'b0, i_stream_data} + {1'b0, cfg_addend};
      OP_ACC:  result = {1'b0, acc} + {1'b0, i_stream_data};
      OP_PASS: result = {1'b0, i_stream_data};
      default: result = '0;
    endcase
  end

  // FIFO storage carries no reset: entries are only visible when counted.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= result[WIDTH-1:0];
    end
  end

  // Pointers and occupancy. Pointer increments wrap naturally because DEPTH
  // is a power of two.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Accumulator and sticky overflow. A coincident clear takes priority over
  // the update from the same beat, but that beat's stored result was already
  // formed from the old accumulator value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc      <= '0;
      overflow <= 1'b0;
    end else if (cfg_clear) begin
      acc      <= '0;
      overflow <= 1'b0;
    end else begin
      if (push && (i_op == OP_ACC)) begin
        acc <= result[WIDTH-1:0];
      end
      if (push && result[WIDTH]) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stream_adder_fifo.sv
// -----------------------------------------------------------------------------
// tb_stream_adder_fifo
//
// Directed scenarios for stream_adder_fifo with WIDTH=32, DEPTH=4, INC=1.
// Inputs are driven and outputs sampled on the falling clock edge; the DUT
// acts on the rising edge in between.
// -----------------------------------------------------------------------------
module tb_stream_adder_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic             clk;
  logic             reset;
  logic             i_stream_val;
  logic             i_stream_rdy;
  logic [WIDTH-1:0] i_stream_data;
  logic [1:0]       i_op;
  logic [WIDTH-1:0] cfg_addend;
  logic             cfg_clear;
  logic             o_stream_val;
  logic             o_stream_rdy;
  logic [WIDTH-1:0] o_stream_data;
  logic [2:0]       o_count;
  logic             o_overflow;
  logic [WIDTH-1:0] o_acc;

  int errors;
  int checks;

  stream_adder_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .INC(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_stream_val  (i_stream_val),
    .i_stream_rdy  (i_stream_rdy),
    .i_stream_data (i_stream_data),
    .i_op          (i_op),
    .cfg_addend    (cfg_addend),
    .cfg_clear     (cfg_clear),
    .o_stream_val  (o_stream_val),
    .o_stream_rdy  (o_stream_rdy),
    .o_stream_data (o_stream_data),
    .o_count       (o_count),
    .o_overflow    (o_overflow),
    .o_acc         (o_acc)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    i_stream_val  = 1'b0;
    i_stream_data = '0;
    i_op          = 2'b11;
    cfg_addend    = '0;
    cfg_clear     = 1'b0;
  endtask

  // Test 0: reset state
  task automatic test_reset();
    idle_inputs();
    o_stream_rdy = 1'b0;
    reset = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    checks++;
    if (o_stream_val !== 1'b0) begin errors++; $display("FAIL reset_val: got %0b expected 0", o_stream_val); end
    checks++;
    if (o_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", o_count); end
    checks++;
    if (i_stream_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %0b expected 1", i_stream_rdy); end
    checks++;
    if (o_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b expected 0", o_overflow); end
  endtask

  // Test 1: OP_INC 5 -> 6, one-cycle latency, popped immediately
  task automatic test_inc();
    o_stream_rdy  = 1'b1;
    i_stream_val  = 1'b1;
    i_stream_data = 32'h0000_0005;
    i_op          = 2'b00;
    checks++;
    if (o_stream_val !== 1'b0) begin errors++; $display("FAIL inc_no_comb_path: got %0b expected 0", o_stream_val); end
    cyc();
    i_stream_val = 1'b0;
    checks++;
    if (o_stream_val !== 1'b1) begin errors++; $display("FAIL inc_val: got %0b expected 1", o_stream_val); end
    checks++;
    if (o_stream_data !== 32'h0000_0006) begin errors++; $display("FAIL inc_data: got %h expected 00000006", o_stream_data); end
    cyc();
    checks++;
    if (o_count !== 3'd0) begin errors++; $display("FAIL inc_count: got %0d expected 0", o_count); end
  endtask

  // Test 2: fill with 5 PASS beats, the fifth is refused; drain in order
  task automatic test_fill();
    logic [WIDTH-1:0] exp;
    o_stream_rdy = 1'b0;
    i_op         = 2'b11;
    for (int i = 0; i < 5; i++) begin
      i_stream_val  = 1'b1;
      i_stream_data = 32'hA0 + i;
      checks++;
      if (i_stream_rdy !== (i < 4)) begin errors++; $display("FAIL fill_rdy%0d: got %0b expected %0b", i, i_stream_rdy, (i < 4)); end
      cyc();
    end
    i_stream_val = 1'b0;
    checks++;
    if (o_count !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d expected 4", o_count); end
    o_stream_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp = 32'hA0 + i;
      checks++;
      if (o_stream_val !== 1'b1 || o_stream_data !== exp) begin
        errors++; $display("FAIL fill_drain%0d: got val=%0b data=%h expected val=1 data=%h", i, o_stream_val, o_stream_data, exp);
      end
      cyc();
    end
    checks++;
    if (o_count !== 3'd0 || o_stream_val !== 1'b0) begin errors++; $display("FAIL fill_empty: got count=%0d val=%0b expected 0 0", o_count, o_stream_val); end
    o_stream_rdy = 1'b0;
  endtask

  // Test 3: full FIFO with pop and offered push in the same cycle
  task automatic test_full_pop();
    logic [WIDTH-1:0] exp;
    o_stream_rdy = 1'b0;
    i_op         = 2'b11;
    for (int i = 0; i < 4; i++) begin
      i_stream_val  = 1'b1;
      i_stream_data = 32'hB0 + i;
      cyc();
    end
    i_stream_data = 32'hB4;
    o_stream_rdy  = 1'b1;
    checks++;
    if (i_stream_rdy !== 1'b0) begin errors++; $display("FAIL full_rdy: got %0b expected 0", i_stream_rdy); end
    cyc();
    checks++;
    if (o_count !== 3'd3) begin errors++; $display("FAIL full_pop_only: got count=%0d expected 3", o_count); end
    checks++;
    if (o_stream_data !== 32'hB1) begin errors++; $display("FAIL full_head: got %h expected 000000b1", o_stream_data); end
    cyc();
    i_stream_val = 1'b0;
    checks++;
    if (o_count !== 3'd3) begin errors++; $display("FAIL full_push_pop: got count=%0d expected 3", o_count); end
    for (int i = 0; i < 3; i++) begin
      exp = 32'hB2 + i;
      checks++;
      if (o_stream_val !== 1'b1 || o_stream_data !== exp) begin
        errors++; $display("FAIL full_drain%0d: got val=%0b data=%h expected val=1 data=%h", i, o_stream_val, o_stream_data, exp);
      end
      cyc();
    end
    checks++;
    if (o_count !== 3'd0) begin errors++; $display("FAIL full_empty: got count=%0d expected 0", o_count); end
    o_stream_rdy = 1'b0;
  endtask

  // Test 4: accumulate, clear, clear coinciding with an ACC push
  task automatic test_acc();
    logic [WIDTH-1:0] exp_v [4];
    exp_v[0] = 32'd3; exp_v[1] = 32'd7; exp_v[2] = 32'd12; exp_v[3] = 32'd1;
    o_stream_rdy = 1'b0;
    i_op         = 2'b10;
    for (int i = 0; i < 3; i++) begin
      i_stream_val  = 1'b1;
      i_stream_data = 32'd3 + i;
      cyc();
    end
    i_stream_val = 1'b0;
    cfg_clear    = 1'b1;
    cyc();
    cfg_clear     = 1'b0;
    i_stream_val  = 1'b1;
    i_stream_data = 32'd1;
    cyc();
    i_stream_val = 1'b0;
    o_stream_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (o_stream_data !== exp_v[i]) begin errors++; $display("FAIL acc_out%0d: got %0d expected %0d", i, o_stream_data, exp_v[i]); end
      cyc();
    end
    // acc is now 1; push 5 with clear -> result 6 from old acc, acc cleared
    i_stream_val  = 1'b1;
    i_stream_data = 32'd5;
    cfg_clear     = 1'b1;
    cyc();
    cfg_clear     = 1'b0;
    i_stream_data = 32'd2;
    checks++;
    if (o_stream_data !== 32'd6) begin errors++; $display("FAIL acc_clear_same: got %0d expected 6", o_stream_data); end
    cyc();
    i_stream_val = 1'b0;
    checks++;
    if (o_stream_data !== 32'd2) begin errors++; $display("FAIL acc_after_clear: got %0d expected 2", o_stream_data); end
    cyc();
    o_stream_rdy = 1'b0;
  endtask

  // Test 5: carry-out sets sticky overflow; PASS never carries
  task automatic test_overflow();
    o_stream_rdy  = 1'b1;
    cfg_clear     = 1'b1;
    cyc();
    cfg_clear     = 1'b0;
    i_stream_val  = 1'b1;
    i_op          = 2'b11;
    i_stream_data = 32'hFFFF_FFFF;
    cyc();
    checks++;
    if (o_overflow !== 1'b0) begin errors++; $display("FAIL ovf_pass: got %0b expected 0", o_overflow); end
    i_op          = 2'b01;
    cfg_addend    = 32'd2;
    cyc();
    i_op          = 2'b11;
    i_stream_data = 32'h10;
    checks++;
    if (o_stream_data !== 32'h0000_0001) begin errors++; $display("FAIL ovf_data: got %h expected 00000001", o_stream_data); end
    checks++;
    if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %0b expected 1", o_overflow); end
    cyc();
    i_stream_val = 1'b0;
    checks++;
    if (o_overflow !== 1'b1 || o_stream_data !== 32'h10) begin
      errors++; $display("FAIL ovf_sticky: got ovf=%0b data=%h expected ovf=1 data=00000010", o_overflow, o_stream_data);
    end
    cyc();
    cfg_clear = 1'b1;
    cyc();
    cfg_clear = 1'b0;
    checks++;
    if (o_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %0b expected 0", o_overflow); end
    // INC wraps 0xFFFFFFFF to 0 and carries
    i_stream_val  = 1'b1;
    i_op          = 2'b00;
    i_stream_data = 32'hFFFF_FFFF;
    cyc();
    i_stream_val = 1'b0;
    checks++;
    if (o_stream_data !== 32'h0 || o_overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_inc_wrap: got data=%h ovf=%0b expected 00000000 1", o_stream_data, o_overflow);
    end
    cyc();
    cfg_addend   = '0;
    o_stream_rdy = 1'b0;
  endtask

  // Test 6: streaming push and pop every cycle keeps occupancy at 1
  task automatic test_back_to_back();
    logic [WIDTH-1:0] exp;
    o_stream_rdy = 1'b1;
    i_op         = 2'b00;
    for (int i = 0; i < 5; i++) begin
      i_stream_val  = (i < 4);
      i_stream_data = 32'd10 + i;
      if (i > 0) begin
        exp = 32'd10 + i;
        checks++;
        if (o_count !== 3'd1 || o_stream_data !== exp) begin
          errors++; $display("FAIL b2b%0d: got count=%0d data=%0d expected 1 %0d", i, o_count, o_stream_data, exp);
        end
      end
      cyc();
    end
    checks++;
    if (o_count !== 3'd0) begin errors++; $display("FAIL b2b_empty: got %0d expected 0", o_count); end
    o_stream_rdy = 1'b0;
  endtask

  // Test 7: reset mid-operation discards queue and accumulator
  task automatic test_reset_mid();
    o_stream_rdy = 1'b0;
    cfg_clear    = 1'b1;
    cyc();
    cfg_clear    = 1'b0;
    i_stream_val = 1'b1;
    i_op         = 2'b10;
    i_stream_data = 32'd4; cyc();
    i_stream_data = 32'd5; cyc();
    i_op          = 2'b11;
    i_stream_data = 32'd7; cyc();
    i_stream_val  = 1'b0;
    checks++;
    if (o_count !== 3'd3 || o_acc !== 32'd9) begin errors++; $display("FAIL rmid_pre: got count=%0d acc=%0d expected 3 9", o_count, o_acc); end
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    checks++;
    if (o_stream_val !== 1'b0 || o_count !== 3'd0) begin
      errors++; $display("FAIL rmid_flush: got val=%0b count=%0d expected 0 0", o_stream_val, o_count);
    end
    i_stream_val  = 1'b1;
    i_op          = 2'b10;
    i_stream_data = 32'd1;
    cyc();
    i_stream_val = 1'b0;
    checks++;
    if (o_stream_val !== 1'b1 || o_stream_data !== 32'd1) begin
      errors++; $display("FAIL rmid_acc: got val=%0b data=%0d expected 1 1", o_stream_val, o_stream_data);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    idle_inputs();
    o_stream_rdy = 1'b0;
    cyc();
    test_reset();
    test_inc();
    test_fill();
    test_full_pop();
    test_acc();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
